// File: rtl/id_control_path.sv
// id_control_path: ID-stage control for the 5-stage ARM pipeline.
// This block holds the fetch PC and its PC+4 adder. It decodes the IF/ID
// instruction into control signals. A bubble mux sits after the decoder,
// and its outputs are registered into the ID/EX control latch.
// Optional build macro CU_CMP_NOWRITE_EN changes the compare/test opcodes
// (TST, TEQ, CMP, CMN). With it defined they never write the register file,
// they always set status_bits[0], and they use ALU ops of their own.
module id_control_path #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_enable,
  input  logic [31:0] instruction,
  input  logic        nop_select,
  output logic [31:0] pc_current,
  output logic [31:0] pc_plus_4,
  output logic        reg_write_enable,
  output logic        mem_write_enable,
  output logic        mem_to_reg_select,
  output logic        alu_source_select,
  output logic [1:0]  status_bits,
  output logic [1:0]  alu_operation,
  output logic        pc_source_select,
  output logic        ex_reg_write,
  output logic        ex_mem_write,
  output logic        ex_mem_to_reg,
  output logic        ex_alu_src,
  output logic [1:0]  ex_alu_operation
);

  logic [31:0] r_pc;
  logic [3:0]  w_cond;
  logic [2:0]  w_class;
  logic [3:0]  w_opcode;
  logic        w_i_bit;
  logic        w_s_bit;
  logic        w_u_bit;
  logic        w_l_bit;

  logic        w_reg_write;
  logic        w_mem_write;
  logic        w_mem_to_reg;
  logic        w_alu_src;
  logic [1:0]  w_status;
  logic [1:0]  w_alu_op;
  logic        w_pc_src;

  logic        w_mux_reg_write;
  logic        w_mux_mem_write;
  logic        w_mux_mem_to_reg;
  logic        w_mux_alu_src;
  logic [1:0]  w_mux_alu_op;

  logic        r_ex_reg_write;
  logic        r_ex_mem_write;
  logic        r_ex_mem_to_reg;
  logic        r_ex_alu_src;
  logic [1:0]  r_ex_alu_op;

  assign w_cond   = instruction[31:28];
  assign w_class  = instruction[27:25];
  assign w_i_bit  = instruction[25];
  assign w_opcode = instruction[24:21];
  assign w_s_bit  = instruction[20];
  assign w_u_bit  = instruction[23];
  assign w_l_bit  = instruction[20];

  assign pc_current = r_pc;
  assign pc_plus_4  = r_pc + PC_STEP;

  // PC register: reset takes priority over the enable; the adder wraps naturally
  always_ff @(posedge clk) begin
    if (reset)
      r_pc <= PC_RESET;
    else if (pc_enable)
      r_pc <= pc_plus_4;
  end

  // Instruction decode; an all-zero word is a NOP even though it looks like AND
  always_comb begin
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src    = 1'b0;
    w_status     = 2'b00;
    w_alu_op     = 2'b00;
    w_pc_src     = 1'b0;
    if (instruction != 32'h0000_0000) begin
      case (w_class)
        3'b000, 3'b001: begin
          w_reg_write = 1'b1;
          w_alu_src   = w_i_bit;
          w_status    = {(w_cond != 4'b1110), w_s_bit};
          case (w_opcode)
            4'b0100: w_alu_op = 2'b00;
            4'b0010: w_alu_op = 2'b01;
            4'b0000: w_alu_op = 2'b10;
            4'b1100: w_alu_op = 2'b11;
            default: w_alu_op = 2'b00;
          endcase
`ifdef CU_CMP_NOWRITE_EN
          if (w_opcode[3:2] == 2'b10) begin
            w_reg_write = 1'b0;
            w_status[0] = 1'b1;
            case (w_opcode[1:0])
              2'b10:   w_alu_op = 2'b01;
              2'b11:   w_alu_op = 2'b00;
              default: w_alu_op = 2'b10;
            endcase
          end
`else
          // compare/test opcodes decode like any other data-processing op
`endif
        end
        3'b010, 3'b011: begin
          w_alu_src    = ~w_i_bit;
          w_alu_op     = w_u_bit ? 2'b00 : 2'b01;
          w_reg_write  = w_l_bit;
          w_mem_to_reg = w_l_bit;
          w_mem_write  = ~w_l_bit;
          w_status     = {(w_cond != 4'b1110), 1'b0};
        end
        3'b101: begin
          w_pc_src    = 1'b1;
          w_alu_src   = 1'b1;
          w_reg_write = instruction[24];
          w_status    = {(w_cond != 4'b1110), 1'b0};
        end
        default: ;
      endcase
    end
  end

  assign reg_write_enable  = w_reg_write;
  assign mem_write_enable  = w_mem_write;
  assign mem_to_reg_select = w_mem_to_reg;
  assign alu_source_select = w_alu_src;
  assign status_bits       = w_status;
  assign alu_operation     = w_alu_op;

  assign w_mux_reg_write  = nop_select ? 1'b0  : w_reg_write;
  assign w_mux_mem_write  = nop_select ? 1'b0  : w_mem_write;
  assign w_mux_mem_to_reg = nop_select ? 1'b0  : w_mem_to_reg;
  assign w_mux_alu_src    = nop_select ? 1'b0  : w_alu_src;
  assign w_mux_alu_op     = nop_select ? 2'b00 : w_alu_op;
  assign pc_source_select = nop_select ? 1'b0  : w_pc_src;

  // ID/EX control latch: loads the bubble-muxed controls every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_reg_write  <= 1'b0;
      r_ex_mem_write  <= 1'b0;
      r_ex_mem_to_reg <= 1'b0;
      r_ex_alu_src    <= 1'b0;
      r_ex_alu_op     <= 2'b00;
    end else begin
      r_ex_reg_write  <= w_mux_reg_write;
      r_ex_mem_write  <= w_mux_mem_write;
      r_ex_mem_to_reg <= w_mux_mem_to_reg;
      r_ex_alu_src    <= w_mux_alu_src;
      r_ex_alu_op     <= w_mux_alu_op;
    end
  end

  assign ex_reg_write     = r_ex_reg_write;
  assign ex_mem_write     = r_ex_mem_write;
  assign ex_mem_to_reg    = r_ex_mem_to_reg;
  assign ex_alu_src       = r_ex_alu_src;
  assign ex_alu_operation = r_ex_alu_op;

endmodule

// File: tb/tb_id_control_path.sv
// Directed bench for id_control_path: PC sequencing, decode, bubble mux, ID/EX latch.
// A second instance with PC_RESET = 0xFFFFFFFC exercises the PC wrap.
module tb_id_control_path;

  logic        clk;
  logic        reset;
  logic        pc_enable;
  logic [31:0] instruction;
  logic        nop_select;

  logic [31:0] pc_current, pc_plus_4;
  logic        reg_write_enable, mem_write_enable, mem_to_reg_select, alu_source_select;
  logic [1:0]  status_bits, alu_operation;
  logic        pc_source_select;
  logic        ex_reg_write, ex_mem_write, ex_mem_to_reg, ex_alu_src;
  logic [1:0]  ex_alu_operation;

  logic [31:0] w_pc_current, w_pc_plus_4;
  logic        w_rw, w_mw, w_m2r, w_as, w_pcs;
  logic [1:0]  w_st, w_op;
  logic        w_ex_rw, w_ex_mw, w_ex_m2r, w_ex_as;
  logic [1:0]  w_ex_op;

  int checks = 0;
  int errors = 0;

  id_control_path dut (
    .clk(clk), .reset(reset), .pc_enable(pc_enable), .instruction(instruction),
    .nop_select(nop_select), .pc_current(pc_current), .pc_plus_4(pc_plus_4),
    .reg_write_enable(reg_write_enable), .mem_write_enable(mem_write_enable),
    .mem_to_reg_select(mem_to_reg_select), .alu_source_select(alu_source_select),
    .status_bits(status_bits), .alu_operation(alu_operation),
    .pc_source_select(pc_source_select), .ex_reg_write(ex_reg_write),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_alu_src(ex_alu_src), .ex_alu_operation(ex_alu_operation)
  );

  id_control_path #(.PC_RESET(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset), .pc_enable(pc_enable), .instruction(instruction),
    .nop_select(nop_select), .pc_current(w_pc_current), .pc_plus_4(w_pc_plus_4),
    .reg_write_enable(w_rw), .mem_write_enable(w_mw),
    .mem_to_reg_select(w_m2r), .alu_source_select(w_as),
    .status_bits(w_st), .alu_operation(w_op),
    .pc_source_select(w_pcs), .ex_reg_write(w_ex_rw),
    .ex_mem_write(w_ex_mw), .ex_mem_to_reg(w_ex_m2r),
    .ex_alu_src(w_ex_as), .ex_alu_operation(w_ex_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // decode vector: {reg_write, mem_write, mem_to_reg, alu_src, status[1:0], alu_op[1:0], pc_src_muxed}
  function automatic logic [8:0] dec_vec();
    return {reg_write_enable, mem_write_enable, mem_to_reg_select, alu_source_select,
            status_bits, alu_operation, pc_source_select};
  endfunction

  // ID/EX vector: {reg_write, mem_write, mem_to_reg, alu_src, alu_op[1:0]}
  function automatic logic [5:0] ex_vec();
    return {ex_reg_write, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_alu_operation};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // apply an instruction, check pre-mux decode, then the ID/EX latch one edge later
  task automatic apply(input string tag, input logic [31:0] instr, input logic nop,
                       input logic [8:0] exp_dec, input logic [5:0] exp_ex);
    instruction = instr;
    nop_select  = nop;
    #1;
    chk({tag, "_dec"}, {23'd0, dec_vec()}, {23'd0, exp_dec});
    tick();
    chk({tag, "_ex"}, {26'd0, ex_vec()}, {26'd0, exp_ex});
  endtask

  initial begin
    reset       = 1'b1;
    pc_enable   = 1'b1;
    nop_select  = 1'b0;
    instruction = 32'hE211_0000;

    // reset held for three edges with a live ANDS on the decode inputs
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_pc", pc_current, 32'h0);
      chk("rst_ex", {26'd0, ex_vec()}, 32'h0);
    end
    chk("wrap_rst_pc", w_pc_current, 32'hFFFF_FFFC);
    chk("wrap_plus4", w_pc_plus_4, 32'h0);

    reset = 1'b0;
    tick();
    chk("pc_4", pc_current, 32'd4);
    chk("plus4_8", pc_plus_4, 32'd8);
    chk("wrap_pc_0", w_pc_current, 32'h0);
    chk("ands_ex_first", {26'd0, ex_vec()}, {26'd0, 6'b100110});
    tick();
    chk("pc_8", pc_current, 32'd8);
    tick();
    chk("pc_12", pc_current, 32'd12);

    pc_enable = 1'b0;
    tick();
    chk("hold_1", pc_current, 32'd12);
    tick();
    chk("hold_2", pc_current, 32'd12);

    apply("ands", 32'hE211_0000, 1'b0, 9'b1_0_0_1_01_10_0, 6'b100110);
    apply("add",  32'hE080_5183, 1'b0, 9'b1_0_0_0_00_00_0, 6'b100000);
    apply("sub",  32'hE041_1002, 1'b0, 9'b1_0_0_0_00_01_0, 6'b100001);
    apply("orr",  32'hE181_1002, 1'b0, 9'b1_0_0_0_00_11_0, 6'b100011);
    apply("ldrb", 32'hE7D1_2000, 1'b0, 9'b1_0_1_0_00_00_0, 6'b101000);
    apply("ldr_u0", 32'hE511_0004, 1'b0, 9'b1_0_1_1_00_01_0, 6'b101101);
    apply("str",  32'hE58A_5000, 1'b0, 9'b0_1_0_1_00_00_0, 6'b010100);
    apply("bne",  32'h1AFF_FFFD, 1'b0, 9'b0_0_0_1_10_00_1, 6'b000100);
    apply("blle", 32'hDB00_0009, 1'b0, 9'b1_0_0_1_10_00_1, 6'b100100);
    apply("ldm",  32'hE8BD_0000, 1'b0, 9'b0_0_0_0_00_00_0, 6'b000000);
`ifdef CU_CMP_NOWRITE_EN
    apply("cmp",  32'hE151_0002, 1'b0, 9'b0_0_0_0_01_01_0, 6'b000001);
    apply("tst",  32'hE111_0002, 1'b0, 9'b0_0_0_0_01_10_0, 6'b000010);
`else
    apply("cmp",  32'hE151_0002, 1'b0, 9'b1_0_0_0_01_00_0, 6'b100000);
    apply("tst",  32'hE111_0002, 1'b0, 9'b1_0_0_0_01_00_0, 6'b100000);
`endif
    apply("ands_bub", 32'hE211_0000, 1'b1, 9'b1_0_0_1_01_10_0, 6'b000000);
    apply("bne_bub",  32'h1AFF_FFFD, 1'b1, 9'b0_0_0_1_10_00_0, 6'b000000);
    apply("nop",      32'h0000_0000, 1'b0, 9'b0_0_0_0_00_00_0, 6'b000000);
    chk("pc_still_12", pc_current, 32'd12);

    // load the latch with ANDS, then reset mid-stream with pc_enable high
    apply("ands_again", 32'hE211_0000, 1'b0, 9'b1_0_0_1_01_10_0, 6'b100110);
    pc_enable = 1'b1;
    reset     = 1'b1;
    tick();
    chk("mid_rst_pc", pc_current, 32'h0);
    chk("mid_rst_ex", {26'd0, ex_vec()}, 32'h0);
    chk("mid_rst_dec", {23'd0, dec_vec()}, {23'd0, 9'b1_0_0_1_01_10_0});
    reset = 1'b0;
    tick();
    chk("post_rst_pc", pc_current, 32'd4);
    chk("post_rst_ex", {26'd0, ex_vec()}, {26'd0, 6'b100110});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
